// File: rtl/iir_pkg.sv
// Shared constants, state encoding and saturation limits for the biquad cascade.
`default_nettype none

package iir_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_FRAC   = 14;
    localparam int DEF_NSEC   = 4;
    localparam int DEF_ACC_W  = 40;

    localparam logic [2:0] B0 = 3'd0;
    localparam logic [2:0] B1 = 3'd1;
    localparam logic [2:0] B2 = 3'd2;
    localparam logic [2:0] A1 = 3'd3;
    localparam logic [2:0] A2 = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2,
        OUT  = 2'd3
    } state_t;

    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/iir_round_sat.sv
// Accumulator-to-sample conversion: optional round-half-up (IIR_ROUND_EN), shift by FRAC, clamp.
`default_nettype none

module iir_round_sat
    import iir_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC   = DEF_FRAC
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] y,
    output logic                     sat
);

    localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(DATA_W));
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(DATA_W));

    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] shifted;

`ifdef IIR_ROUND_EN
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);
    assign rounded = acc + HALF;
`else
    assign rounded = acc;
`endif

    assign shifted = rounded >>> FRAC;

    always_comb begin
        sat = 1'b0;
        y   = shifted[DATA_W-1:0];
        if (shifted > HI) begin
            y   = HI[DATA_W-1:0];
            sat = 1'b1;
        end else if (shifted < LO) begin
            y   = LO[DATA_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/iir_biquad_cascade.sv
// NSEC direct-form-I biquads sharing one MAC; rounding mode selected by IIR_ROUND_EN.
`default_nettype none

module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int FRAC   = DEF_FRAC,
    parameter int NSEC   = DEF_NSEC,
    parameter int ACC_W  = DEF_ACC_W,
    localparam int SEC_W = (NSEC > 1) ? $clog2(NSEC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] y_out,
    input  logic                     coef_we,
    input  logic [SEC_W-1:0]         coef_sec,
    input  logic [2:0]               coef_idx,
    input  logic signed [COEF_W-1:0] coef_wdata,
    input  logic                     state_clr,
    output logic                     sat_flag
);

    localparam int PROD_W = COEF_W + DATA_W;
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << FRAC);

    state_t                    state;
    logic [SEC_W-1:0]          sec;
    logic [2:0]                tap;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DATA_W-1:0]  xs;

    logic signed [COEF_W-1:0]  coef [NSEC][5];
    logic signed [DATA_W-1:0]  x1 [NSEC];
    logic signed [DATA_W-1:0]  x2 [NSEC];
    logic signed [DATA_W-1:0]  y1 [NSEC];
    logic signed [DATA_W-1:0]  y2 [NSEC];

    logic signed [DATA_W-1:0]  opnd;
    logic signed [COEF_W-1:0]  coef_sel;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_base;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [DATA_W-1:0]  ys;
    logic                      ys_sat;
    logic                      sec_ok;

    always_comb begin
        opnd = xs;
        case (tap)
            B0:      opnd = xs;
            B1:      opnd = x1[sec];
            B2:      opnd = x2[sec];
            A1:      opnd = y1[sec];
            A2:      opnd = y2[sec];
            default: opnd = xs;
        endcase
    end

    assign coef_sel = coef[sec][tap];
    assign prod     = PROD_W'(coef_sel) * PROD_W'(opnd);
    // Tap 0 starts a fresh sum; feedback taps subtract.
    assign acc_base = (tap == B0) ? '0 : acc;
    assign acc_sum  = (tap >= A1) ? acc_base - ACC_W'(prod) : acc_base + ACC_W'(prod);
    assign sec_ok   = 32'(coef_sec) < NSEC;

    iir_round_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC   (FRAC)
    ) u_round_sat (
        .acc (acc),
        .y   (ys),
        .sat (ys_sat)
    );

    // Coefficients only change between samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NSEC; s++)
                for (int k = 0; k < 5; k++)
                    coef[s][k] <= (k == 0) ? COEF_ONE : '0;
        end else if (coef_we && state == IDLE && coef_idx <= A2 && sec_ok) begin
            coef[coef_sec][coef_idx] <= coef_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            y_out     <= '0;
            sat_flag  <= 1'b0;
            sec       <= '0;
            tap       <= '0;
            acc       <= '0;
            xs        <= '0;
            for (int s = 0; s < NSEC; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
        end else if (state_clr) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            sec       <= '0;
            tap       <= '0;
            for (int s = 0; s < NSEC; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        xs       <= x_in;
                        sec      <= '0;
                        tap      <= '0;
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    if (tap == A2) begin
                        tap   <= '0;
                        state <= WB;
                    end else begin
                        tap <= tap + 3'd1;
                    end
                end
                WB: begin
                    x2[sec] <= x1[sec];
                    x1[sec] <= xs;
                    y2[sec] <= y1[sec];
                    y1[sec] <= ys;
                    xs      <= ys;
                    if (ys_sat)
                        sat_flag <= 1'b1;
                    if (sec == SEC_W'(NSEC - 1)) begin
                        y_out     <= ys;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        sec   <= sec + 1'b1;
                        state <= MAC;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
